// File: rtl/pwm_modulator_if.sv
// Signal bundle between the PWM modulator and its controller/gate-driver side.
// slave = modulator view, master = controller/testbench view.
interface pwm_modulator_if;
   logic [31:0]        counter;
   logic signed [15:0] waveform;
   logic signed [15:0] cmd;
   logic               cmd_valid;
   logic               cmd_ready;
   logic               fault;
   logic               fault_clr;
   logic               pwm_hi;
   logic               pwm_lo;
   logic signed [15:0] cmd_active;
   logic               faulted;

   modport slave (
      input  counter, waveform, cmd, cmd_valid, fault, fault_clr,
      output cmd_ready, pwm_hi, pwm_lo, cmd_active, faulted
   );

   modport master (
      output counter, waveform, cmd, cmd_valid, fault, fault_clr,
      input  cmd_ready, pwm_hi, pwm_lo, cmd_active, faulted
   );
endinterface

// File: rtl/pwm_modulator.sv
// Carrier-compare PWM with period-aligned command shadowing, fault latch and
// optional dead-time insertion (enabled by defining PWM_DEADTIME_EN).
module pwm_modulator #(
   parameter int PERIOD          = 1000,
   parameter int DEADTIME_CYCLES = 8
) (
   input  logic             clk,
   input  logic             rst,
   pwm_modulator_if.slave   io_pwm
);

   localparam logic [31:0] LAST_COUNT = 32'(PERIOD - 1);

   if (DEADTIME_CYCLES < 1 || DEADTIME_CYCLES > 255) begin : g_deadtimeRange
      $error("DEADTIME_CYCLES must be within 1..255");
   end

   typedef enum logic [2:0] {
      OFF,
      HI_ON,
      LO_ON,
`ifdef PWM_DEADTIME_EN
      DEAD,
`endif
      FAULT
   } state_t;

   state_t             r_state;
   state_t             w_nextState;
   logic               r_pwmHi;
   logic               r_pwmLo;
   logic               r_faulted;
   logic               r_rawQ;
   logic signed [15:0] r_shadow;
   logic signed [15:0] r_cmdActive;
   logic               r_pending;
   logic               r_readyEn;
   logic               w_cmdReady;
   logic               w_start;

`ifdef PWM_DEADTIME_EN
   localparam logic [7:0] DEAD_LOAD = 8'(DEADTIME_CYCLES - 1);

   logic       r_target;
   logic       w_nextTarget;
   logic [7:0] r_deadCnt;
   logic [7:0] w_nextDeadCnt;
`endif

   // cmd_ready is held low through reset and its first clock edge.
   assign w_cmdReady = r_readyEn & ~r_pending;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_readyEn   <= 1'b0;
         r_pending   <= 1'b0;
         r_shadow    <= '0;
         r_cmdActive <= '0;
         r_rawQ      <= 1'b0;
      end else begin
         r_readyEn <= 1'b1;
         r_rawQ    <= (io_pwm.waveform < r_cmdActive);
         if (io_pwm.cmd_valid && w_cmdReady) begin
            r_shadow  <= io_pwm.cmd;
            r_pending <= 1'b1;
         end else if (r_pending && (io_pwm.counter == LAST_COUNT)) begin
            r_cmdActive <= r_shadow;
            r_pending   <= 1'b0;
         end
      end
   end

   // Any event that asks the bridge to (re)align with the comparator output.
   assign w_start = (r_state == OFF)
                 || ((r_state == FAULT) && io_pwm.fault_clr)
                 || ((r_state == HI_ON) && !r_rawQ)
                 || ((r_state == LO_ON) && r_rawQ);

   always_comb begin
      w_nextState = r_state;
`ifdef PWM_DEADTIME_EN
      w_nextTarget  = r_target;
      w_nextDeadCnt = r_deadCnt;
`endif
      if (io_pwm.fault) begin
         w_nextState = FAULT;
`ifdef PWM_DEADTIME_EN
      end else if (r_state == DEAD) begin
         if (r_rawQ != r_target) begin
            w_nextTarget  = r_rawQ;
            w_nextDeadCnt = DEAD_LOAD;
         end else if (r_deadCnt == 8'd0) begin
            w_nextState = r_target ? HI_ON : LO_ON;
         end else begin
            w_nextDeadCnt = r_deadCnt - 8'd1;
         end
      end else if (w_start) begin
         w_nextState   = DEAD;
         w_nextTarget  = r_rawQ;
         w_nextDeadCnt = DEAD_LOAD;
`else
      end else if (w_start) begin
         w_nextState = r_rawQ ? HI_ON : LO_ON;
`endif
      end
   end

   // Gate drives are decoded from the next state so they switch with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= OFF;
         r_pwmHi   <= 1'b0;
         r_pwmLo   <= 1'b0;
         r_faulted <= 1'b0;
`ifdef PWM_DEADTIME_EN
         r_target  <= 1'b0;
         r_deadCnt <= 8'd0;
`endif
      end else begin
         r_state   <= w_nextState;
         r_pwmHi   <= (w_nextState == HI_ON);
         r_pwmLo   <= (w_nextState == LO_ON);
         r_faulted <= (w_nextState == FAULT);
`ifdef PWM_DEADTIME_EN
         r_target  <= w_nextTarget;
         r_deadCnt <= w_nextDeadCnt;
`endif
      end
   end

   assign io_pwm.cmd_ready  = w_cmdReady;
   assign io_pwm.cmd_active = r_cmdActive;
   assign io_pwm.pwm_hi     = r_pwmHi;
   assign io_pwm.pwm_lo     = r_pwmLo;
   assign io_pwm.faulted    = r_faulted;

endmodule
